vend_return_ctrl: RTL

VEND_RETURN_CTRL -- requirements
Module: vend_return_ctrl

---
 rtl/vend_return_ctrl_pkg.sv | 37 +++
 rtl/vend_return_ctrl_idle_timer.sv | 40 ++++
 rtl/vend_return_ctrl.sv | 114 +++++++++++
 3 files changed

// File: rtl/vend_return_ctrl_pkg.sv
//==============================================================================
// Module      : vend_return_ctrl_pkg
// Description : Shared vending definitions: coin values, coin bit positions,
//               return-FSM state encoding and default idle timeout.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package vend_return_ctrl_pkg;

    localparam int unsigned c_WAIT_CYCLES_DEFAULT = 100;

    localparam int unsigned c_COIN_100_VAL  = 100;
    localparam int unsigned c_COIN_500_VAL  = 500;
    localparam int unsigned c_COIN_1000_VAL = 1000;

    localparam int unsigned c_COIN_100_BIT  = 0;
    localparam int unsigned c_COIN_500_BIT  = 1;
    localparam int unsigned c_COIN_1000_BIT = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RETURN = 2'd1,
        ST_DONE   = 2'd2
    } ret_state_t;

    // Value in won of a one-hot coin vector; zero when no coin is dispensed.
    function automatic int unsigned coin_value(input logic [2:0] coin);
        if (coin[c_COIN_1000_BIT]) return c_COIN_1000_VAL;
        if (coin[c_COIN_500_BIT])  return c_COIN_500_VAL;
        if (coin[c_COIN_100_BIT])  return c_COIN_100_VAL;
        return 0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/vend_return_ctrl_idle_timer.sv
//==============================================================================
// Module      : vend_idle_timer
// Description : Saturating idle counter; expired while the count sits at
//               WAIT_CYCLES-1.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module vend_idle_timer
    import vend_return_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = c_WAIT_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int unsigned   CNT_W  = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(WAIT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && (r_count != c_LAST)) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expired = (r_count == c_LAST);

endmodule

`default_nettype wire

// File: rtl/vend_return_ctrl.sv
//==============================================================================
// Module      : vend_return_ctrl
// Description : Coin-return controller: greedily pays out the sampled balance
//               one coin per cycle on request or after an idle timeout.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module vend_return_ctrl
    import vend_return_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_CYCLES = c_WAIT_CYCLES_DEFAULT,
    parameter int unsigned BAL_W       = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [BAL_W-1:0] i_balance,
    input  logic             i_trigger_return,
    input  logic             i_activity,
    output logic [2:0]       o_return_coin,
    output logic             o_busy,
    output logic             o_done
);

    ret_state_t       r_state;
    ret_state_t       w_state_nxt;
    logic [BAL_W-1:0] r_remain;
    logic [BAL_W-1:0] w_remain_nxt;
    logic [BAL_W-1:0] w_remain_sub;
    logic [2:0]       w_coin;
    logic             w_idle;
    logic             w_bal_zero;
    logic             w_timer_clear;
    logic             w_expired;

    assign w_idle        = (r_state == ST_IDLE);
    assign w_bal_zero    = (i_balance == '0);
    // Leaving IDLE always clears the counter so each IDLE visit starts fresh.
    assign w_timer_clear = !w_idle || i_activity || w_bal_zero;

    vend_idle_timer #(
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_idle_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (w_timer_clear),
        .enable  (w_idle),
        .expired (w_expired)
    );

    // Coin decode sees only registered state, never the inputs.
    always_comb begin
        w_coin = 3'b000;
        if (r_state == ST_RETURN) begin
            if (r_remain >= BAL_W'(c_COIN_1000_VAL)) begin
                w_coin[c_COIN_1000_BIT] = 1'b1;
            end else if (r_remain >= BAL_W'(c_COIN_500_VAL)) begin
                w_coin[c_COIN_500_BIT] = 1'b1;
            end else if (r_remain >= BAL_W'(c_COIN_100_VAL)) begin
                w_coin[c_COIN_100_BIT] = 1'b1;
            end
        end
        w_remain_sub = r_remain - BAL_W'(coin_value(w_coin));
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_remain_nxt = r_remain;
        case (r_state)
            ST_IDLE: begin
                if (i_trigger_return || (w_expired && !w_bal_zero)) begin
                    if (w_bal_zero) begin
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_state_nxt  = ST_RETURN;
                        w_remain_nxt = i_balance;
                    end
                end
            end
            ST_RETURN: begin
                w_remain_nxt = w_remain_sub;
                // A residue below the smallest coin cannot be paid and is dropped.
                if (w_remain_sub < BAL_W'(c_COIN_100_VAL)) begin
                    w_state_nxt  = ST_DONE;
                    w_remain_nxt = '0;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_remain_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_remain <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_remain <= w_remain_nxt;
        end
    end

    assign o_return_coin = w_coin;
    assign o_busy        = (r_state == ST_RETURN) || (r_state == ST_DONE);
    assign o_done        = (r_state == ST_DONE);

endmodule

`default_nettype wire
